frame_sequencer: RTL and testbench

Frame-level controller for the UART Sobel pipeline. It sits between the byte-widener output and `rgb2gray`, and between `sobel` and the byte-narrower.

- Admits exactly one frame of `linewidth_px_p*frame_lines_p` RGB pixels.
- Injects zero pixels to flush the Sobel line buffers.
- Discards the warm-up results and forwards exactly one frame of results, with a last flag.
- Pulses `frame_done_o` when the frame is complete, then re-arms for the next frame.

---
 rtl/frame_sequencer.sv | 139 +++++++++++++
 tb/tb_frame_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame-level controller for the UART Sobel pipeline: admits one frame of pixels,
// injects flush pixels, drops warm-up results and forwards one frame of results.
module frame_sequencer #(
  parameter int unsigned linewidth_px_p = 480,
  parameter int unsigned frame_lines_p  = 480,
  parameter int unsigned warmup_px_p    = linewidth_px_p + 1,
  parameter int unsigned width_out_p    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  input  logic [31:0]            in_data_i,
  output logic                   in_ready_o,
  output logic                   pix_valid_o,
  output logic [31:0]            pix_data_o,
  input  logic                   pix_ready_i,
  input  logic                   res_valid_i,
  input  logic [width_out_p-1:0] res_data_i,
  output logic                   res_ready_o,
  output logic                   out_valid_o,
  output logic [width_out_p-1:0] out_data_o,
  output logic                   out_last_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [2:0]             state_o
);

  localparam int unsigned frame_px_lp = linewidth_px_p * frame_lines_p;
  localparam int unsigned total_lp    = frame_px_lp + warmup_px_p;
  localparam int unsigned cnt_w_lp    = $clog2(total_lp + 1);

  localparam logic [cnt_w_lp-1:0] frame_px_c   = cnt_w_lp'(frame_px_lp);
  localparam logic [cnt_w_lp-1:0] frame_m1_c   = cnt_w_lp'(frame_px_lp - 1);
  localparam logic [cnt_w_lp-1:0] frame_last_c = cnt_w_lp'(frame_px_lp - 1);
  localparam logic [cnt_w_lp-1:0] total_c      = cnt_w_lp'(total_lp);
  localparam logic [cnt_w_lp-1:0] total_m1_c   = cnt_w_lp'(total_lp - 1);
  localparam logic [cnt_w_lp-1:0] warmup_c     = cnt_w_lp'(warmup_px_p);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e              state_q, state_nxt;
  logic [cnt_w_lp-1:0] in_cnt_q, res_cnt_q, res_cnt_inc;
  logic                frame_done_q;
  logic                active, pix_hs, res_hs, res_counted;
  logic [cnt_w_lp:0]   k_rel;
  logic                in_warmup, past_end, forward, is_last;

  assign active = (state_q == STREAM) || (state_q == FLUSH) || (state_q == DRAIN);
  assign pix_hs = pix_valid_o & pix_ready_i;
  assign res_hs = res_valid_i & res_ready_o;

  // Result index relative to the first forwarded result; the borrow bit marks warm-up.
  assign k_rel     = {1'b0, res_cnt_q} - {1'b0, warmup_c};
  assign in_warmup = k_rel[cnt_w_lp];
  assign past_end  = !in_warmup && (k_rel[cnt_w_lp-1:0] >= frame_px_c);
  assign is_last   = !in_warmup && (k_rel[cnt_w_lp-1:0] == frame_last_c);
  assign forward   = !in_warmup && !past_end;

  assign res_counted = active && res_hs && (res_cnt_q != total_c);
  assign res_cnt_inc = res_cnt_q + cnt_w_lp'(res_counted);

  // State, counters and the done pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      res_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      frame_done_q <= (state_nxt == DONE);
      if (state_q == IDLE) begin
        in_cnt_q  <= '0;
        res_cnt_q <= '0;
      end else begin
        if (pix_hs && (in_cnt_q != total_c)) in_cnt_q <= in_cnt_q + cnt_w_lp'(1);
        res_cnt_q <= res_cnt_inc;
      end
    end
  end

  // Next state and pixel-side outputs.
  always_comb begin
    state_nxt   = state_q;
    in_ready_o  = 1'b0;
    pix_valid_o = 1'b0;
    pix_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) state_nxt = STREAM;
      end
      STREAM: begin
        pix_valid_o = in_valid_i;
        pix_data_o  = in_data_i;
        in_ready_o  = pix_ready_i;
        if (in_valid_i && pix_ready_i && (in_cnt_q == frame_m1_c))
          state_nxt = (warmup_px_p == 0) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        pix_valid_o = 1'b1;
        if (pix_ready_i && (in_cnt_q == total_m1_c)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (res_cnt_inc == total_c) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result side: forward the frame window, drop everything else.
  always_comb begin
    res_ready_o = 1'b1;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    if (active && forward) begin
      out_valid_o = res_valid_i;
      res_ready_o = out_ready_i;
      out_last_o  = is_last;
    end
  end

  assign out_data_o   = res_data_i;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: two instances (warm-up 5 and 0) driven by
// a scenario table plus hand-written reset and stray-result sequences.
module tb_frame_sequencer;

  localparam int unsigned lw = 4;
  localparam int unsigned fl = 3;
  localparam int unsigned np = 12;
  localparam int unsigned ow = 16;
  localparam int budget = 600;

  typedef struct {
    int          dut;
    int          offered;
    bit          stall;
    int          exp_acc;
    int          exp_flush;
    int          exp_out;
    int          exp_done;
    logic [31:0] exp_seq;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [1:0]    in_valid, in_ready, pix_valid, pix_ready, res_valid, res_ready;
  logic [1:0]    out_valid, out_last, out_ready, busy, frame_done;
  logic [31:0]   in_data  [2];
  logic [31:0]   pix_data [2];
  logic [ow-1:0] res_data [2];
  logic [ow-1:0] out_data [2];
  logic [2:0]    state    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    frame_sequencer #(
      .linewidth_px_p(lw),
      .frame_lines_p (fl),
      .warmup_px_p   ((g == 0) ? 5 : 0),
      .width_out_p   (ow)
    ) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .in_valid_i  (in_valid[g]),
      .in_data_i   (in_data[g]),
      .in_ready_o  (in_ready[g]),
      .pix_valid_o (pix_valid[g]),
      .pix_data_o  (pix_data[g]),
      .pix_ready_i (pix_ready[g]),
      .res_valid_i (res_valid[g]),
      .res_data_i  (res_data[g]),
      .res_ready_o (res_ready[g]),
      .out_valid_o (out_valid[g]),
      .out_data_o  (out_data[g]),
      .out_last_o  (out_last[g]),
      .out_ready_i (out_ready[g]),
      .busy_o      (busy[g]),
      .frame_done_o(frame_done[g]),
      .state_o     (state[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sobel stand-in: result j is garbage during warm-up, else f(pixel j-warmup).
  logic [31:0]   hist [2][256];
  int            hc [2], rc [2], stray [2];
  // Per-instance observations.
  int            n_in [2], n_flush [2], n_out [2], n_done [2];
  logic [ow-1:0] odata [2][64];
  bit            olast [2][64];
  logic [31:0]   seq [2];
  logic [2:0]    last_st [2];
  bit            stall_prev [2], last_prev [2], acc [2], hs_pix [2], hs_res [2];
  logic [ow-1:0] stall_data [2];
  logic [31:0]   pd_s [2];
  int            total, bad;
  vec_t          vecs [5];

  function automatic int wu(int d);
    return (d == 0) ? 5 : 0;
  endfunction

  function automatic logic [ow-1:0] f(logic [31:0] p);
    return {p[23:16] ^ p[15:8], p[7:0]};
  endfunction

  function automatic logic [31:0] pval(int s, int i);
    return 32'h00A0_0000 | (32'(s + 1) << 8) | 32'(i + 1);
  endfunction

  function automatic logic [ow-1:0] model_res(int d, int j);
    if (j < wu(d)) return 16'hE000 | 16'(j);
    return f(hist[d][(j - wu(d)) % 256]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_res();
    for (int d = 0; d < 2; d++) begin
      if (stray[d] > 0) begin
        res_valid[d] = 1'b1;
        res_data[d]  = 16'hBEEF;
      end else if (rc[d] < hc[d]) begin
        res_valid[d] = 1'b1;
        res_data[d]  = model_res(d, rc[d]);
      end else begin
        res_valid[d] = 1'b0;
        res_data[d]  = '0;
      end
    end
  endtask

  task automatic sample();
    for (int d = 0; d < 2; d++) begin
      hs_pix[d] = pix_valid[d] && pix_ready[d];
      acc[d]    = in_valid[d] && in_ready[d];
      hs_res[d] = res_valid[d] && res_ready[d];
      pd_s[d]   = pix_data[d];
      if (state[d] == 3'd2 || state[d] == 3'd3 || state[d] == 3'd4)
        check("in_ready_blocked", 32'(in_ready[d]), 32'd0);
      if (stray[d] > 0) begin
        check("stray_res_ready", 32'(res_ready[d]), 32'd1);
        check("stray_out_valid", 32'(out_valid[d]), 32'd0);
      end
      if (stall_prev[d]) begin
        check("stall_valid_hold", 32'(out_valid[d]), 32'd1);
        check("stall_data_hold", 32'(out_data[d]), 32'(stall_data[d]));
      end
      stall_prev[d] = out_valid[d] && !out_ready[d];
      stall_data[d] = out_data[d];
      if (frame_done[d] || last_prev[d])
        check("done_after_last", 32'(frame_done[d]), 32'(last_prev[d]));
      if (frame_done[d]) begin
        check("busy_at_done", 32'(busy[d]), 32'd1);
        n_done[d]++;
      end
      if (acc[d]) n_in[d]++;
      if (hs_pix[d] && !acc[d]) begin
        n_flush[d]++;
        check("flush_zero", pix_data[d], 32'd0);
      end
      last_prev[d] = 1'b0;
      if (out_valid[d] && out_ready[d]) begin
        if (n_out[d] < 64) begin
          odata[d][n_out[d]] = out_data[d];
          olast[d][n_out[d]] = out_last[d];
        end
        n_out[d]++;
        last_prev[d] = out_last[d];
      end
      if (state[d] != last_st[d]) begin
        seq[d]     = (seq[d] << 4) | 32'(state[d]);
        last_st[d] = state[d];
      end
    end
  endtask

  task automatic cycle();
    drive_res();
    #1;
    sample();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (hs_pix[d]) begin
        hist[d][hc[d] % 256] = pd_s[d];
        hc[d]++;
      end
      if (hs_res[d]) begin
        if (stray[d] > 0) stray[d]--;
        else rc[d]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_rec(int d);
    n_in[d] = 0; n_flush[d] = 0; n_out[d] = 0; n_done[d] = 0;
    stall_prev[d] = 1'b0; last_prev[d] = 1'b0;
    last_st[d] = state[d];
    seq[d] = 32'hF0 | 32'(state[d]);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0;
      pix_ready[d] = 1'b1; out_ready[d] = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hc[d] = 0; rc[d] = 0; stray[d] = 0;
      clear_rec(d);
    end
    drive_res();
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_state", 32'(state[d]), 32'd0);
      check("rst_in_ready", 32'(in_ready[d]), 32'd0);
      check("rst_pix_valid", 32'(pix_valid[d]), 32'd0);
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out_last", 32'(out_last[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_frame_done", 32'(frame_done[d]), 32'd0);
      check("rst_res_ready", 32'(res_ready[d]), 32'd1);
    end
  endtask

  task automatic run_vec(input int s, input vec_t v, input bit do_rst);
    int p, cyc, tail, d;
    d = v.dut;
    idle_inputs();
    if (do_rst) do_reset();
    clear_rec(d);
    p = 0; cyc = 0; tail = 0;
    while (tail < 6 && cyc < budget) begin
      in_valid[d]  = (p < v.offered);
      in_data[d]   = (p < v.offered) ? pval(s, p) : 32'd0;
      pix_ready[d] = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready[d] = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      cyc++;
      if (acc[d]) p++;
      if (p >= v.offered && n_done[d] >= v.exp_done) tail++;
    end
    idle_inputs();
    check("no_timeout", 32'(cyc < budget), 32'd1);
    check("accepted", 32'(n_in[d]), 32'(v.exp_acc));
    check("flush_count", 32'(n_flush[d]), 32'(v.exp_flush));
    check("out_count", 32'(n_out[d]), 32'(v.exp_out));
    check("done_count", 32'(n_done[d]), 32'(v.exp_done));
    check("state_seq", seq[d], v.exp_seq);
    for (int i = 0; i < n_out[d] && i < 64; i++) begin
      check("out_data", 32'(odata[d][i]), 32'(f(pval(s, i))));
      check("out_last", 32'(olast[d][i]), 32'((i % np) == (np - 1)));
    end
  endtask

  initial begin
    int p;
    total = 0; bad = 0; reset = 1'b0;
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      hc[d] = 0; rc[d] = 0; stray[d] = 0;
      stall_prev[d] = 1'b0; last_prev[d] = 1'b0;
    end
    //          dut offer stall acc flush out done seq
    vecs[0] = '{0, 12, 1'b0, 12, 5, 12, 1, 32'hF012340};
    vecs[1] = '{0, 12, 1'b1, 12, 5, 12, 1, 32'hF012340};
    vecs[2] = '{0, 20, 1'b0, 20, 5, 15, 1, 32'hF0123401};
    vecs[3] = '{1, 12, 1'b0, 12, 0, 12, 1, 32'hF01340};
    vecs[4] = '{1, 12, 1'b1, 12, 0, 12, 1, 32'hF01340};
    @(negedge clk);

    for (int s = 0; s < 5; s++) run_vec(s, vecs[s], 1'b1);

    // Reset after 7 accepted pixels, pixel 8 still offered.
    idle_inputs();
    do_reset();
    p = 0;
    for (int c = 0; c < 100 && p < 7; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = pval(5, p);
      cycle();
      if (acc[0]) p++;
    end
    check("mid_accepted", 32'(p), 32'd7);
    in_data[0] = pval(5, 7);
    do_reset();
    run_vec(0, vecs[0], 1'b0);

    // Stray results while idle, then a normal frame.
    idle_inputs();
    do_reset();
    stray[0] = 3;
    for (int c = 0; c < 20 && stray[0] > 0; c++) cycle();
    check("stray_consumed", 32'(stray[0]), 32'd0);
    check("stray_state_idle", 32'(state[0]), 32'd0);
    check("stray_no_out", 32'(n_out[0]), 32'd0);
    run_vec(0, vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
